// File: rtl/muldiv_pkg.sv
// Shared opcodes, FSM state encoding and configuration check for the
// iterative multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_MULT  = 3'b000;
    localparam logic [OP_W-1:0] OP_MULTU = 3'b001;
    localparam logic [OP_W-1:0] OP_DIV   = 3'b010;
    localparam logic [OP_W-1:0] OP_DIVU  = 3'b011;
    localparam logic [OP_W-1:0] OP_MTHI  = 3'b100;
    localparam logic [OP_W-1:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        RUN  = 2'd2,
        FIX  = 2'd3
    } state_t;

    // Legal iteration widths: 1, 2 or 4 bits, dividing the operand width.
    function automatic bit step_bits_ok(input int unsigned width, input int unsigned step);
        return ((step == 1) || (step == 2) || (step == 4)) &&
               (width > step) && ((width % step) == 0);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath: STEP_BITS of shift-add
// multiplication or restoring shift-subtract division per evaluation.
module muldiv_step #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned STEP_BITS = 1
) (
    input  logic [2*WIDTH-1:0]   i_part,
    input  logic [WIDTH-1:0]     i_operand,
    input  logic                 i_div,
    output logic [2*WIDTH-1:0]   o_part,
    output logic [STEP_BITS-1:0] o_qbits
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned SW = WIDTH + STEP_BITS;

    logic [WIDTH:0]          w_rem;
    logic [WIDTH-1:0]        w_dvd;
    logic [WIDTH-1:0]        w_q;
    logic                    w_ge;
    logic [SW-1:0]           w_sum;
    logic [PW+STEP_BITS-1:0] w_cat;

    // Divide: i_part = {remainder, dividend bits not yet consumed}; quotient
    // bits leave on o_qbits and the low STEP_BITS of o_part are left zero.
    // Multiply: i_part = {accumulator, multiplier bits not yet consumed}, LSB first.
    always_comb begin
        o_part  = '0;
        o_qbits = '0;
        w_rem   = '0;
        w_dvd   = '0;
        w_q     = '0;
        w_ge    = 1'b0;
        w_sum   = '0;
        w_cat   = '0;
        if (i_div) begin
            w_rem = {1'b0, i_part[PW-1:WIDTH]};
            w_dvd = i_part[WIDTH-1:0];
            for (int i = 0; i < int'(STEP_BITS); i++) begin
                w_rem = {w_rem[WIDTH-1:0], w_dvd[WIDTH-1]};
                w_dvd = {w_dvd[WIDTH-2:0], 1'b0};
                w_ge  = (w_rem >= {1'b0, i_operand});
                if (w_ge) begin
                    w_rem = w_rem - {1'b0, i_operand};
                end
                w_q = {w_q[WIDTH-2:0], w_ge};
            end
            o_part  = {w_rem[WIDTH-1:0], w_dvd};
            o_qbits = w_q[STEP_BITS-1:0];
        end else begin
            w_sum  = SW'(i_part[PW-1:WIDTH]) + SW'(i_operand) * SW'(i_part[STEP_BITS-1:0]);
            w_cat  = {w_sum, i_part[WIDTH-1:0]};
            o_part = PW'(w_cat >> STEP_BITS);
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, cancel on flush
// and overrun reporting for the EX stage.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned STEP_BITS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             overrun,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned N     = WIDTH / STEP_BITS;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW    = 2 * WIDTH;

    if (!step_bits_ok(WIDTH, STEP_BITS)) begin : g_bad_cfg
        $error("muldiv_unit: STEP_BITS must be 1, 2 or 4 and divide WIDTH");
    end

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_signed;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_opnd;
    logic [PW-1:0]      r_part;
    logic               r_busy;
    logic               r_done;
    logic               r_overrun;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_op_md;
    logic               w_launch;
    logic               w_mthi;
    logic               w_mtlo;
    logic               w_commit;
    logic               w_overrun;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [PW-1:0]      w_step_part;
    logic [STEP_BITS-1:0] w_qbits;
    logic [PW-1:0]      w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_op_md = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);

    // Magnitudes and result signs, consumed in PREP.
    assign w_a_neg = r_signed & r_a[WIDTH-1];
    assign w_b_neg = r_signed & r_b[WIDTH-1];
    assign w_abs_a = w_a_neg ? -r_a : r_a;
    assign w_abs_b = w_b_neg ? -r_b : r_b;

    // Sign correction applied in FIX; most-negative / -1 falls out naturally.
    assign w_prod = r_neg_q ? -r_part : r_part;
    assign w_quo  = r_neg_q ? -r_part[WIDTH-1:0] : r_part[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_part[PW-1:WIDTH] : r_part[PW-1:WIDTH];

    muldiv_step #(
        .WIDTH     (WIDTH),
        .STEP_BITS (STEP_BITS)
    ) u_step (
        .i_part    (r_part),
        .i_operand (r_opnd),
        .i_div     (r_is_div),
        .o_part    (w_step_part),
        .o_qbits   (w_qbits)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Cancel outranks start and the FIX commit.
    always_comb begin
        w_next_state = r_state;
        w_launch     = 1'b0;
        w_mthi       = 1'b0;
        w_mtlo       = 1'b0;
        w_commit     = 1'b0;
        w_overrun    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !cancel) begin
                    if (w_op_md) begin
                        w_next_state = PREP;
                        w_launch     = 1'b1;
                    end
                    w_mthi = (op == OP_MTHI);
                    w_mtlo = (op == OP_MTLO);
                end
            end
            PREP: begin
                w_next_state = cancel ? IDLE : RUN;
            end
            RUN: begin
                if (cancel) begin
                    w_next_state = IDLE;
                end else if (r_cnt == '0) begin
                    w_next_state = FIX;
                end
            end
            FIX: begin
                w_next_state = IDLE;
                w_commit     = !cancel;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        w_overrun = start && !cancel && (r_state != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_signed  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz      <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_opnd    <= '0;
            r_part    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_busy    <= (w_next_state != IDLE);
            r_done    <= w_commit;
            r_overrun <= w_overrun;
            if (w_launch) begin
                r_is_div <= (op == OP_DIV) || (op == OP_DIVU);
                r_signed <= (op == OP_MULT) || (op == OP_DIV);
                r_a      <= a;
                r_b      <= b;
            end
            if (w_mthi) begin
                r_hi <= a;
            end
            if (w_mtlo) begin
                r_lo <= a;
            end
            if (r_state == PREP) begin
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
                r_dz    <= r_is_div && (r_b == '0);
                r_cnt   <= CNT_W'(N - 1);
                r_opnd  <= r_is_div ? w_abs_b : w_abs_a;
                r_part  <= {{WIDTH{1'b0}}, (r_is_div ? w_abs_a : w_abs_b)};
            end
            if (r_state == RUN) begin
                r_part <= w_step_part | PW'(w_qbits);
                r_cnt  <= r_cnt - CNT_W'(1);
            end
            if (w_commit) begin
                if (!r_is_div) begin
                    {r_hi, r_lo} <= w_prod;
                end else if (r_dz) begin
                    r_hi <= r_a;
                    r_lo <= '1;
                end else begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign overrun = r_overrun;
    assign hi      = r_hi;
    assign lo      = r_lo;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with HI/LO registers for the 5-stage pipeline's EX stage.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO as a multi-cycle side unit.
- Exposes busy to the hazard logic. Supports cancel on pipeline flush.
- Iteration width per cycle is configurable, trading latency against area.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- STEP_BITS, 1, quotient/multiplier bits processed per RUN cycle; must be 1, 2 or 4 and divide WIDTH.
- N (derived, localparam), WIDTH/STEP_BITS, number of RUN cycles.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- start  in  1  request; sampled on the rising edge.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
- a  in  WIDTH  rs operand (multiplicand/dividend; source for MTHI/MTLO).
- b  in  WIDTH  rt operand (multiplier/divisor).
- cancel  in  1  flush; aborts the in-flight operation.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when a MULT/DIV result is committed.
- overrun  out  1  one-cycle pulse when start arrives while busy.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset=0, async): state=IDLE; hi=lo=0; busy=done=overrun=0; all internal accumulators cleared.
  - Reset mid-operation abandons the operation with no partial commit.
- States: IDLE, PREP, RUN, FIX.
  - IDLE: if start & ~cancel & op in {MULT, MULTU, DIV, DIVU}, go to PREP; latch op, a and b.
  - PREP (1 cycle): signed ops take absolute values and record result signs; load the iteration counter with N-1; go to RUN.
  - RUN (N cycles): each cycle retires STEP_BITS. MUL uses shift-add; DIV uses restoring shift-subtract. After the counter reaches 0, go to FIX.
  - FIX (1 cycle): apply sign correction; write hi and lo on the exiting edge; go to IDLE.
- Timing, with start sampled at edge E0:
  - busy is high for cycles 1..N+2.
  - Results are visible and done=1 in cycle N+3.
  - busy is registered (state != IDLE), never combinational from start.
- MTHI/MTLO (IDLE only): write hi or lo from a at the sampling edge and are visible the next cycle. No busy, no done.
- Reserved ops: ignored, no outputs change.
- Result definitions:
  - MULT/MULTU: {hi,lo} = full 2*WIDTH product.
  - DIV/DIVU: lo = quotient, hi = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Division by zero (b=0, signed or unsigned): lo = all ones, hi = a. Takes the full latency; done still pulses.
- Signed overflow (a = most-negative, b = -1): lo = a, hi = 0.
- cancel:
  - cancel=1 in PREP/RUN/FIX: go to IDLE at the next edge. hi/lo are unchanged and no done pulse occurs.
  - cancel in FIX beats the commit.
  - cancel has priority over start in the same cycle, including MTHI/MTLO.
- start while busy (and no cancel): the request is ignored and overrun pulses the next cycle. The pipeline is required to stall, so overrun indicates a hazard-logic bug.
- The pipeline must stall MFHI/MFLO while busy=1. hi/lo hold their old values throughout an operation until the FIX commit.

Decomposition:
- muldiv_pkg holds:
  - op code constants: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO;
  - the state enum: IDLE, PREP, RUN, FIX;
  - the STEP_BITS legality check function.
- Sub-module muldiv_step: a combinational single-iteration datapath, parametrised by WIDTH and STEP_BITS.
  - Inputs: partial remainder/product, operand, mode.
  - Outputs: next partial value and STEP_BITS quotient bits.
  - muldiv_unit instantiates it once; muldiv_unit itself owns the FSM, counter, sign handling and HI/LO.

Test Plan (WIDTH=32, STEP_BITS=1, so N=32, done in cycle 35):
- MULT a=0xFFFFFFFD, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy for cycles 1..34; done=1 only in cycle 35.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Repeat with STEP_BITS=4 -> same result, done in cycle 11.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Interrupted operations:
  - Preload hi=0xAAAA via MTHI (visible the next cycle).
  - Start MULT, raise cancel in cycle 10 -> busy=0 in cycle 11, hi=0xAAAA, no done.
  - Start DIV, drive start again in cycle 5 -> overrun=1 in cycle 6; the original result commits unchanged.
- Drive reset=0 in cycle 20 of a DIV -> immediately busy=0, hi=lo=0. After release, a fresh MULTU 3*5 -> lo=15, hi=0.
